// File: rtl/clkdiv_pkg.sv
// Shared types and default widths for the clock-divider scale sequencer.
package clkdiv_pkg;

    localparam int DEF_SCALE_W = 8;
    localparam int DEF_DWELL_W = 8;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        SWEEP     = 2'd2
    } state_t;

    // Origin of the value held in the pending register
    typedef enum logic {
        SRC_HOST  = 1'b0,
        SRC_SWEEP = 1'b1
    } src_t;

endpackage

// File: rtl/clkdiv_sweep_step.sv
// Combinational next-scale computation for the automatic sweep.
// Direction follows the ordering of start/stop; reaching stop wraps to start,
// so the arithmetic never runs past the programmed range.
module clkdiv_sweep_step
    import clkdiv_pkg::*;
#(
    parameter int SCALE_W = DEF_SCALE_W
) (
    input  logic [SCALE_W-1:0] scale_cur,
    input  logic [SCALE_W-1:0] sweep_start,
    input  logic [SCALE_W-1:0] sweep_stop,
    output logic [SCALE_W-1:0] scale_next
);

    localparam logic [SCALE_W-1:0] ONE = SCALE_W'(1);

    // Wrap at the stop value, otherwise step one toward stop
    always_comb begin
        scale_next = scale_cur;
        if (scale_cur == sweep_stop) begin
            scale_next = sweep_start;
        end else if (sweep_start <= sweep_stop) begin
            scale_next = scale_cur + ONE;
        end else begin
            scale_next = scale_cur - ONE;
        end
    end

endmodule

// File: rtl/clkdiv_scale_sequencer.sv
// Owns the divider's scale word. Arbitrates host requests against an
// automatic sweep and applies every new scale only at a divider period
// boundary so the divided clock never sees a runt pulse.
module clkdiv_scale_sequencer
    import clkdiv_pkg::*;
#(
    parameter int SCALE_W = DEF_SCALE_W,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               host_req,
    input  logic [SCALE_W-1:0] host_scale,
    output logic               host_ack,
    input  logic               sweep_en,
    input  logic [SCALE_W-1:0] sweep_start,
    input  logic [SCALE_W-1:0] sweep_stop,
    input  logic [DWELL_W-1:0] sweep_dwell,
    input  logic               div_period_end,
    output logic [SCALE_W-1:0] scale_out,
    output logic               scale_load,
    output logic               busy,
    output logic               sweep_active
);

    state_t             state_q, state_d;
    src_t               src_q, src_d;
    logic [SCALE_W-1:0] pending_q, pending_d;
    logic [SCALE_W-1:0] scale_q, scale_d;
    logic               load_q, load_d;
    logic               ack_q, ack_d;
    logic               active_q, active_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               sweep_en_q, sweep_en_d;
    logic               host_ready_q, host_ready_d;

    logic [SCALE_W-1:0] sweep_next;
    logic [DWELL_W-1:0] dwell_eff;
    logic [DWELL_W:0]   dwell_cnt_inc;
    logic               step_due;
    logic               boundary;
    logic               sweep_rise;
    logic               host_take;

    clkdiv_sweep_step #(
        .SCALE_W (SCALE_W)
    ) u_sweep_step (
        .scale_cur   (scale_q),
        .sweep_start (sweep_start),
        .sweep_stop  (sweep_stop),
        .scale_next  (sweep_next)
    );

    // Boundary, edge detection and dwell bookkeeping
    always_comb begin
        // A stopped divider (scale 0) has no period ends, so any edge is safe
        boundary      = div_period_end | (scale_q == '0);
        sweep_rise    = sweep_en & ~sweep_en_q;
        host_take     = host_req & host_ready_q;
        dwell_eff     = (sweep_dwell == '0) ? DWELL_W'(1) : sweep_dwell;
        dwell_cnt_inc = {1'b0, dwell_cnt_q} + (DWELL_W + 1)'(1);
        // The period end that performs the load is the last one of the dwell,
        // so the next value is armed once all earlier period ends have passed
        step_due      = dwell_cnt_inc >= {1'b0, dwell_eff};
    end

    // Next-state logic for the control FSM, handshake and dwell counter
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        pending_d    = pending_q;
        scale_d      = scale_q;
        load_d       = 1'b0;
        ack_d        = 1'b0;
        active_d     = active_q;
        dwell_cnt_d  = dwell_cnt_q;
        sweep_en_d   = sweep_en;
        host_ready_d = host_ready_q;

        // Re-arm the host only once its request has been seen low outside
        // an outstanding host load
        if (!host_req && !(state_q == WAIT_EDGE && src_q == SRC_HOST)) begin
            host_ready_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (host_take) begin
                    pending_d    = host_scale;
                    src_d        = SRC_HOST;
                    host_ready_d = 1'b0;
                    state_d      = WAIT_EDGE;
                end else if (sweep_rise) begin
                    pending_d = sweep_start;
                    src_d     = SRC_SWEEP;
                    active_d  = 1'b1;
                    state_d   = WAIT_EDGE;
                end
            end

            WAIT_EDGE: begin
                if (boundary) begin
                    scale_d     = pending_q;
                    load_d      = 1'b1;
                    dwell_cnt_d = '0;
                    if (src_q == SRC_HOST) begin
                        ack_d   = 1'b1;
                        state_d = IDLE;
                    end else if (sweep_en) begin
                        state_d = SWEEP;
                    end else begin
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end

            SWEEP: begin
                if (host_take) begin
                    // Host pre-empts the sweep; a new sweep_en rise is needed
                    pending_d    = host_scale;
                    src_d        = SRC_HOST;
                    host_ready_d = 1'b0;
                    active_d     = 1'b0;
                    dwell_cnt_d  = '0;
                    state_d      = WAIT_EDGE;
                end else if (!sweep_en) begin
                    active_d    = 1'b0;
                    dwell_cnt_d = '0;
                    state_d     = IDLE;
                end else if (step_due) begin
                    dwell_cnt_d = '0;
                    if (div_period_end) begin
                        // Boundary already here: load without a wait cycle
                        scale_d = sweep_next;
                        load_d  = 1'b1;
                    end else begin
                        pending_d = sweep_next;
                        src_d     = SRC_SWEEP;
                        state_d   = WAIT_EDGE;
                    end
                end else if (div_period_end) begin
                    dwell_cnt_d = dwell_cnt_inc[DWELL_W-1:0];
                end
            end

            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            src_q        <= SRC_HOST;
            pending_q    <= '0;
            scale_q      <= '0;
            load_q       <= 1'b0;
            ack_q        <= 1'b0;
            active_q     <= 1'b0;
            dwell_cnt_q  <= '0;
            sweep_en_q   <= 1'b0;
            host_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            pending_q    <= pending_d;
            scale_q      <= scale_d;
            load_q       <= load_d;
            ack_q        <= ack_d;
            active_q     <= active_d;
            dwell_cnt_q  <= dwell_cnt_d;
            sweep_en_q   <= sweep_en_d;
            host_ready_q <= host_ready_d;
        end
    end

    assign scale_out    = scale_q;
    assign scale_load   = load_q;
    assign host_ack     = ack_q;
    assign busy         = (state_q == WAIT_EDGE);
    assign sweep_active = active_q;

endmodule

// File: tb/tb_clkdiv_scale_sequencer.sv
// Directed bench for the scale sequencer: hand-written host handshake and
// reset sequences plus a per-cycle vector table for the sweep scenarios.
module tb_clkdiv_scale_sequencer;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       host_req = 1'b0;
    logic [7:0] host_scale = 8'd0;
    logic       host_ack;
    logic       sweep_en = 1'b0;
    logic [7:0] sweep_start = 8'd0;
    logic [7:0] sweep_stop = 8'd0;
    logic [7:0] sweep_dwell = 8'd0;
    logic       div_period_end = 1'b0;
    logic [7:0] scale_out;
    logic       scale_load;
    logic       busy;
    logic       sweep_active;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       hr;
        logic [7:0] hs;
        logic       en;
        logic [7:0] st;
        logic [7:0] sp;
        logic [7:0] dw;
        logic       pe;
        logic [7:0] so;
        logic       ld;
        logic       ack;
        logic       bsy;
        logic       act;
    } vec_t;

    vec_t vecs[$];

    clkdiv_scale_sequencer #(
        .SCALE_W (8),
        .DWELL_W (8)
    ) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .host_req       (host_req),
        .host_scale     (host_scale),
        .host_ack       (host_ack),
        .sweep_en       (sweep_en),
        .sweep_start    (sweep_start),
        .sweep_stop     (sweep_stop),
        .sweep_dwell    (sweep_dwell),
        .div_period_end (div_period_end),
        .scale_out      (scale_out),
        .scale_load     (scale_load),
        .busy           (busy),
        .sweep_active   (sweep_active)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] so, input logic ld,
                              input logic ack, input logic bsy, input logic act);
        $display("%s: scale_out=%0d scale_load=%0b host_ack=%0b busy=%0b sweep_active=%0b",
                 tag, scale_out, scale_load, host_ack, busy, sweep_active);
        chk({tag, " scale_out"},    32'(scale_out),    32'(so));
        chk({tag, " scale_load"},   32'(scale_load),   32'(ld));
        chk({tag, " host_ack"},     32'(host_ack),     32'(ack));
        chk({tag, " busy"},         32'(busy),         32'(bsy));
        chk({tag, " sweep_active"}, 32'(sweep_active), 32'(act));
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic add(input logic hr, input logic [7:0] hs, input logic en,
                       input logic [7:0] st, input logic [7:0] sp, input logic [7:0] dw,
                       input logic pe, input logic [7:0] so, input logic ld,
                       input logic ack, input logic bsy, input logic act);
        vec_t v;
        v.hr = hr; v.hs = hs; v.en = en; v.st = st; v.sp = sp; v.dw = dw; v.pe = pe;
        v.so = so; v.ld = ld; v.ack = ack; v.bsy = bsy; v.act = act;
        vecs.push_back(v);
    endtask

    initial begin
        // ---- vector table: expected outputs after the edge that samples the row ----
        // up sweep 3..5, two periods per step
        add(0,  0,1,3,5,2,0,  20,0,0,1,1);
        add(0,  0,1,3,5,2,1,   3,1,0,0,1);
        add(0,  0,1,3,5,2,0,   3,0,0,0,1);
        add(0,  0,1,3,5,2,1,   3,0,0,0,1);
        add(0,  0,1,3,5,2,0,   3,0,0,1,1);
        add(0,  0,1,3,5,2,0,   3,0,0,1,1);
        add(0,  0,1,3,5,2,1,   4,1,0,0,1);
        add(0,  0,1,3,5,2,0,   4,0,0,0,1);
        add(0,  0,1,3,5,2,1,   4,0,0,0,1);
        add(0,  0,1,3,5,2,0,   4,0,0,1,1);
        add(0,  0,1,3,5,2,1,   5,1,0,0,1);
        add(0,  0,1,3,5,2,0,   5,0,0,0,1);
        add(0,  0,1,3,5,2,1,   5,0,0,0,1);
        add(0,  0,1,3,5,2,0,   5,0,0,1,1);
        add(0,  0,1,3,5,2,1,   3,1,0,0,1);
        add(0,  0,1,3,5,2,0,   3,0,0,0,1);
        add(0,  0,1,3,5,2,1,   3,0,0,0,1);
        add(0,  0,1,3,5,2,0,   3,0,0,1,1);
        add(0,  0,1,3,5,2,1,   4,1,0,0,1);
        add(0,  0,0,3,5,2,0,   4,0,0,0,0);
        add(0,  0,0,3,5,2,1,   4,0,0,0,0);
        // down sweep 5..3, dwell 0 behaves as 1
        add(0,  0,1,5,3,0,0,   4,0,0,1,1);
        add(0,  0,1,5,3,0,1,   5,1,0,0,1);
        add(0,  0,1,5,3,0,0,   5,0,0,1,1);
        add(0,  0,1,5,3,0,1,   4,1,0,0,1);
        add(0,  0,1,5,3,0,0,   4,0,0,1,1);
        add(0,  0,1,5,3,0,1,   3,1,0,0,1);
        add(0,  0,1,5,3,0,0,   3,0,0,1,1);
        add(0,  0,1,5,3,0,1,   5,1,0,0,1);
        // host pre-empts the sweep; sweep does not resume while sweep_en stays high
        add(1, 50,1,5,3,0,0,   5,0,0,1,0);
        add(1, 50,1,5,3,0,0,   5,0,0,1,0);
        add(1, 50,1,5,3,0,1,  50,1,1,0,0);
        add(1, 50,1,5,3,0,1,  50,0,0,0,0);
        add(0, 50,1,5,3,0,0,  50,0,0,0,0);
        add(0, 50,1,5,3,0,1,  50,0,0,0,0);
        add(0, 50,0,5,3,0,0,  50,0,0,0,0);
        // host and sweep rise together: host wins, sweep edge consumed
        add(1,  7,1,5,3,0,0,  50,0,0,1,0);
        add(1,  7,1,5,3,0,1,   7,1,1,0,0);
        add(0,  7,1,5,3,0,0,   7,0,0,0,0);
        add(0,  7,0,5,3,0,0,   7,0,0,0,0);
        // sweep_en drops during the sweep's first pending load
        add(0,  0,1,3,5,1,0,   7,0,0,1,1);
        add(0,  0,0,3,5,1,0,   7,0,0,1,1);
        add(0,  0,0,3,5,1,1,   3,1,0,0,0);
        add(0,  0,0,3,5,1,0,   3,0,0,0,0);
        // start == stop: same value reloaded each dwell
        add(0,  0,1,6,6,1,0,   3,0,0,1,1);
        add(0,  0,1,6,6,1,1,   6,1,0,0,1);
        add(0,  0,1,6,6,1,0,   6,0,0,1,1);
        add(0,  0,1,6,6,1,1,   6,1,0,0,1);
        add(0,  0,0,6,6,1,0,   6,0,0,0,0);

        // ---- reset state ----
        rst = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        expect_out("reset", 8'd0, 0, 0, 0, 0);
        @(negedge clk_in);
        rst = 1'b0;
        step();
        step();

        // ---- host load while divider stopped: loads on the next edge ----
        host_req = 1'b1; host_scale = 8'd10;
        step();
        expect_out("host10 latch", 8'd0, 0, 0, 1, 0);
        step();
        expect_out("host10 load", 8'd10, 1, 1, 0, 0);
        step();
        expect_out("host10 held", 8'd10, 0, 0, 0, 0);
        host_req = 1'b0;
        step();

        // ---- host load waits for the period end ----
        host_req = 1'b1; host_scale = 8'd20;
        step();
        expect_out("host20 latch", 8'd10, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            expect_out($sformatf("host20 wait%0d", i), 8'd10, 0, 0, 1, 0);
        end
        div_period_end = 1'b1;
        step();
        expect_out("host20 load", 8'd20, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            div_period_end = (i == 1);
            step();
            expect_out($sformatf("host20 held%0d", i), 8'd20, 0, 0, 0, 0);
        end
        div_period_end = 1'b0;
        host_req = 1'b0;
        step();

        // ---- table-driven sweep scenarios ----
        for (int i = 0; i < vecs.size(); i++) begin
            host_req       = vecs[i].hr;
            host_scale     = vecs[i].hs;
            sweep_en       = vecs[i].en;
            sweep_start    = vecs[i].st;
            sweep_stop     = vecs[i].sp;
            sweep_dwell    = vecs[i].dw;
            div_period_end = vecs[i].pe;
            step();
            expect_out($sformatf("vec%0d", i), vecs[i].so, vecs[i].ld, vecs[i].ack,
                       vecs[i].bsy, vecs[i].act);
        end
        div_period_end = 1'b0;
        sweep_en = 1'b0;

        // ---- reset during a pending host load ----
        host_req = 1'b1; host_scale = 8'd99;
        step();
        expect_out("rst pending", 8'd6, 0, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("rst async", 8'd0, 0, 0, 0, 0);
        @(negedge clk_in);
        rst = 1'b0;
        div_period_end = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("rst held%0d", i), 8'd0, 0, 0, 0, 0);
        end
        div_period_end = 1'b0;
        host_req = 1'b0;
        step();
        host_req = 1'b1;
        step();
        expect_out("rst rereq latch", 8'd0, 0, 0, 1, 0);
        step();
        expect_out("rst rereq load", 8'd99, 1, 1, 0, 0);
        host_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
